// File: rtl/fpu_pkg.sv
// Shared FPU add-path types: default widths and the sign-magnitude operand/result payloads.
package fpu_pkg;

  localparam int unsigned DEF_FRAC_W = 26;
  localparam int unsigned DEF_EXP_W  = 8;

  typedef struct packed {
    logic                  sign;
    logic [DEF_FRAC_W-1:0] frac;
  } sm_op_t;

  typedef struct packed {
    logic                  sign;
    logic [DEF_FRAC_W-1:0] frac;
    logic                  carry;
    logic                  zero;
    logic [DEF_EXP_W-1:0]  exp;
  } frac_res_t;

endpackage

// File: rtl/sm_to_tc.sv
// Sign-magnitude to two's complement, widened by two bits so the later sum cannot overflow.
module sm_to_tc
  import fpu_pkg::*;
#(
  parameter int unsigned W = DEF_FRAC_W
) (
  input  logic         sign,
  input  logic [W-1:0] frac,
  output logic [W+1:0] tc_c
);

  logic [W+1:0] ext;

  always_comb begin
    ext  = {2'b00, frac};
    tc_c = sign ? -ext : ext;
  end

endmodule

// File: rtl/fp_frac_add_pipe.sv
// Two-stage aligned-fraction adder: S1 converts operands to two's complement,
// S2 adds and converts back to sign-magnitude with carry/zero flags.
module fp_frac_add_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned EXP_W  = DEF_EXP_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [FRAC_W-1:0] frac1,
  input  logic              sign1,
  input  logic [FRAC_W-1:0] frac2,
  input  logic              sign2,
  input  logic [EXP_W-1:0]  exp_max_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [FRAC_W-1:0] sum,
  output logic              carry_out,
  output logic              zero_out,
  output logic [EXP_W-1:0]  exp_max_out
);

  localparam int unsigned TC_W  = FRAC_W + 2;
  localparam int unsigned MAG_W = FRAC_W + 1;

  logic [TC_W-1:0]  tc1_c, tc2_c;
  logic             s1_valid;
  logic [TC_W-1:0]  s1_a1, s1_a2;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_en, s2_en;
  logic [TC_W-1:0]  s_sum;
  logic [MAG_W-1:0] s_mag;
  logic             s_neg, s_zero;

  sm_to_tc #(.W(FRAC_W)) u_tc1 (
    .sign (sign1),
    .frac (frac1),
    .tc_c (tc1_c)
  );

  // Subtract mode flips the effective sign of operand 2.
  sm_to_tc #(.W(FRAC_W)) u_tc2 (
    .sign (sign2 ^ op_sub),
    .frac (frac2),
    .tc_c (tc2_c)
  );

  always_comb begin
    s2_en    = !out_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
  end

  // |s| < 2^(FRAC_W+1), so the magnitude always fits in FRAC_W+1 bits.
  always_comb begin
    s_sum  = s1_a1 + s1_a2;
    s_neg  = s_sum[TC_W-1];
    s_mag  = MAG_W'(s_neg ? -s_sum : s_sum);
    s_zero = (s_sum == '0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid <= 1'b0;
      s1_a1    <= '0;
      s1_a2    <= '0;
      s1_exp   <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a1  <= tc1_c;
        s1_a2  <= tc2_c;
        s1_exp <= exp_max_in;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid   <= 1'b0;
      sign_out    <= 1'b0;
      sum         <= '0;
      carry_out   <= 1'b0;
      zero_out    <= 1'b0;
      exp_max_out <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign_out    <= s_neg;
        sum         <= s_mag[FRAC_W-1:0];
        carry_out   <= s_mag[FRAC_W];
        zero_out    <= s_zero;
        exp_max_out <= s_zero ? '0 : s1_exp;
      end
    end
  end

endmodule

// File: tb/tb_fp_frac_add_pipe.sv
// Bench for fp_frac_add_pipe: directed cases plus randomized streams against an integer reference model.
module tb_fp_frac_add_pipe;
  import fpu_pkg::*;

  localparam int unsigned FW = DEF_FRAC_W;
  localparam int unsigned EW = DEF_EXP_W;

  logic          CLK, nRST;
  logic          in_valid, in_ready, op_sub;
  logic [FW-1:0] frac1, frac2;
  logic          sign1, sign2;
  logic [EW-1:0] exp_max_in;
  logic          out_valid, out_ready;
  logic          sign_out, carry_out, zero_out;
  logic [FW-1:0] sum;
  logic [EW-1:0] exp_max_out;

  int        n_vec, n_err;
  frac_res_t obs;
  frac_res_t exp_q[$];

  assign obs = {sign_out, sum, carry_out, zero_out, exp_max_out};

  fp_frac_add_pipe #(.FRAC_W(FW), .EXP_W(EW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_sub      (op_sub),
    .frac1       (frac1),
    .sign1       (sign1),
    .frac2       (frac2),
    .sign2       (sign2),
    .exp_max_in  (exp_max_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sign_out    (sign_out),
    .sum         (sum),
    .carry_out   (carry_out),
    .zero_out    (zero_out),
    .exp_max_out (exp_max_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Signed-integer reference: add the signed values, then split into sign/magnitude.
  function automatic frac_res_t model(input logic sg1, input logic [FW-1:0] f1,
                                      input logic sg2, input logic [FW-1:0] f2,
                                      input logic sub, input logic [EW-1:0] e);
    longint    v1, v2, r, mag;
    frac_res_t res;
    v1 = longint'(f1);
    if (sg1) v1 = -v1;
    v2 = longint'(f2);
    if (sg2 ^ sub) v2 = -v2;
    r   = v1 + v2;
    mag = (r < 0) ? -r : r;
    res.sign  = (r < 0);
    res.frac  = FW'(mag);
    res.carry = mag[FW];
    res.zero  = (r == 0);
    res.exp   = res.zero ? '0 : e;
    return res;
  endfunction

  function automatic frac_res_t model_cur();
    return model(sign1, frac1, sign2, frac2, op_sub, exp_max_in);
  endfunction

  task automatic idle();
    in_valid   = 1'b0;
    op_sub     = 1'b0;
    sign1      = 1'b0;
    sign2      = 1'b0;
    frac1      = '0;
    frac2      = '0;
    exp_max_in = '0;
  endtask

  task automatic set_op(input logic sg1, input logic [FW-1:0] f1,
                        input logic sg2, input logic [FW-1:0] f2,
                        input logic sub, input logic [EW-1:0] e);
    sign1 = sg1; frac1 = f1; sign2 = sg2; frac2 = f2; op_sub = sub; exp_max_in = e;
  endtask

  task automatic rand_op();
    logic [FW-1:0] a, b;
    a = FW'($urandom);
    b = FW'($urandom);
    case ($urandom_range(0, 3))
      0: ;
      1: b = a;
      2: begin a = '1; b = '1; end
      default: begin a = FW'($urandom_range(0, 3)); b = FW'($urandom_range(0, 3)); end
    endcase
    set_op(1'($urandom), a, 1'($urandom), b, 1'($urandom), EW'($urandom));
  endtask

  task automatic test_reset();
    idle();
    out_ready = 1'b1;
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (obs !== frac_res_t'(0)) begin n_err++; $display("FAIL reset_data: got %h want 0", obs); end
    nRST = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    frac_res_t expd;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      case (i)
        0: begin set_op(0, 26'h2000000, 0, 26'h1000000, 0, 8'h80); expd = {1'b0, 26'h3000000, 1'b0, 1'b0, 8'h80}; end
        1: begin set_op(0, 26'h3FFFFFF, 0, 26'h0000001, 0, 8'h7F); expd = {1'b0, 26'h0000000, 1'b1, 1'b0, 8'h7F}; end
        2: begin set_op(0, 26'h1000000, 0, 26'h1800000, 1, 8'h85); expd = {1'b1, 26'h0800000, 1'b0, 1'b0, 8'h85}; end
        3: begin set_op(0, 26'h1234567, 1, 26'h1234567, 0, 8'h90); expd = {1'b0, 26'h0000000, 1'b0, 1'b1, 8'h00}; end
        4: begin set_op(1, 26'h0000000, 1, 26'h0000000, 0, 8'h22); expd = {1'b0, 26'h0000000, 1'b0, 1'b1, 8'h00}; end
        default: begin set_op(1, 26'h3FFFFFF, 1, 26'h3FFFFFF, 0, 8'h11); expd = {1'b1, 26'h3FFFFFE, 1'b1, 1'b0, 8'h11}; end
      endcase
      in_valid = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid); end
      @(negedge CLK);
      #1;
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency: got out_valid %b want 1", i, out_valid); end
      n_vec++;
      if (obs !== expd) begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, obs, expd); end
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    frac_res_t e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge CLK);
      in_valid = (c < 10);
      if (c < 10) rand_op();
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
      n_vec++;
      if (out_valid !== ((c >= 2) && (c < 12))) begin
        n_err++; $display("FAIL b2b_valid c%0d: got %b want %b", c, out_valid, ((c >= 2) && (c < 12)));
      end
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL b2b_data c%0d: got %h want %h", c, obs, e); end
      end
      if (in_valid && in_ready) exp_q.push_back(model_cur());
    end
    idle();
  endtask

  task automatic test_backpressure();
    frac_res_t e, prev_obs;
    int  sent, rcvd, stall_left;
    bit  pending, saw_block, prev_stalled;
    exp_q.delete();
    sent = 0; rcvd = 0; stall_left = 0; pending = 0; saw_block = 0; prev_stalled = 0;
    prev_obs = '0;
    for (int c = 0; c < 30 && rcvd < 4; c++) begin
      @(negedge CLK);
      if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = 1'b1;
      if (sent < 4 && !pending) begin rand_op(); pending = 1; end
      in_valid = pending;
      #1;
      if (prev_stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          n_err++; $display("FAIL bp_hold c%0d: got v=%b %h want v=1 %h", c, out_valid, obs, prev_obs);
        end
      end
      if (!in_ready) saw_block = 1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_extra c%0d: got result %h want none", c, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_err++; $display("FAIL bp_data c%0d: got %h want %h", c, obs, e); end
        end
        rcvd++;
        if (rcvd == 1) stall_left = 3;
      end
      if (in_valid && in_ready) begin exp_q.push_back(model_cur()); sent++; pending = 0; end
      prev_stalled = out_valid && !out_ready;
      prev_obs = obs;
    end
    idle();
    out_ready = 1'b1;
    n_vec++;
    if (saw_block !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_drop: got %b want 1", saw_block); end
    n_vec++;
    if (rcvd != 4 || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_count: got %0d results (%0d pending) want 4 (0)", rcvd, exp_q.size());
    end
    @(negedge CLK);
  endtask

  task automatic test_random();
    frac_res_t e, prev_obs;
    bit prev_stalled;
    exp_q.delete();
    prev_stalled = 0;
    prev_obs = '0;
    for (int c = 0; c < 410; c++) begin
      @(negedge CLK);
      if (c < 400) begin
        out_ready = ($urandom_range(0, 9) < 6);
        in_valid  = ($urandom_range(0, 9) < 7);
        rand_op();
      end else begin
        out_ready = 1'b1;
        idle();
      end
      #1;
      if (prev_stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          n_err++; $display("FAIL rnd_hold c%0d: got v=%b %h want v=1 %h", c, out_valid, obs, prev_obs);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra c%0d: got result %h want none", c, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_err++; $display("FAIL rnd_data c%0d: got %h want %h", c, obs, e); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model_cur());
      prev_stalled = out_valid && !out_ready;
      prev_obs = obs;
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    frac_res_t e;
    @(negedge CLK);
    out_ready = 1'b0;
    rand_op();
    in_valid = 1'b1;
    @(negedge CLK);
    rand_op();
    @(negedge CLK);
    idle();
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL rmf_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    #1 nRST = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmf_async_clear: got %b want 0", out_valid); end
    n_vec++;
    if (obs !== frac_res_t'(0)) begin n_err++; $display("FAIL rmf_data_clear: got %h want 0", obs); end
    @(negedge CLK);
    nRST = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmf_discard c%0d: got %b want 0", c, out_valid); end
    end
    @(negedge CLK);
    set_op(0, 26'h0ABCDEF, 1, 26'h0123456, 0, 8'h42);
    e = model_cur();
    in_valid = 1'b1;
    @(negedge CLK);
    idle();
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmf_early: got %b want 0", out_valid); end
    @(negedge CLK);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || obs !== e) begin
      n_err++; $display("FAIL rmf_first: got v=%b %h want v=1 %h", out_valid, obs, e);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nRST = 1'b0;
    out_ready = 1'b1;
    idle();
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
